// File: rtl/cc_exec_latch_pkg.sv
// Shared Y86-64 encodings: instruction codes, condition selectors, the "no register" ID
// and the condition-code flag bundle.
package y86_pkg;

  localparam int WIDTH = 64;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [3:0] {
    C_ALWAYS = 4'd0,
    C_LE     = 4'd1,
    C_L      = 4'd2,
    C_E      = 4'd3,
    C_NE     = 4'd4,
    C_GE     = 4'd5,
    C_G      = 4'd6
  } cond_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/cc_exec_latch_if.sv
// Execute-stage inputs and E->M latch outputs of the condition-code / pipeline-latch block.
interface cc_exec_latch_if #(
  parameter int WIDTH = y86_pkg::WIDTH
);
  logic [3:0]       e_icode;
  logic [3:0]       e_ifun;
  logic [3:0]       e_dstE;
  logic [WIDTH-1:0] alu_sum;
  logic             alu_ovf;
  logic             set_cc;
  logic             cc_block;
  logic             m_stall;
  logic             m_bubble;

  logic             e_cnd;
  logic             cc_zf;
  logic             cc_sf;
  logic             cc_of;
  logic [3:0]       m_icode;
  logic             m_cnd;
  logic [3:0]       m_dstE;
  logic [WIDTH-1:0] m_valE;

  modport master (
    output e_icode, e_ifun, e_dstE, alu_sum, alu_ovf,
    output set_cc, cc_block, m_stall, m_bubble,
    input  e_cnd, cc_zf, cc_sf, cc_of,
    input  m_icode, m_cnd, m_dstE, m_valE
  );

  modport slave (
    input  e_icode, e_ifun, e_dstE, alu_sum, alu_ovf,
    input  set_cc, cc_block, m_stall, m_bubble,
    output e_cnd, cc_zf, cc_sf, cc_of,
    output m_icode, m_cnd, m_dstE, m_valE
  );
endinterface

// File: rtl/cc_exec_latch_cond_eval.sv
// Purely combinational jXX/cmovXX condition evaluation from the Y86 flags.
// Shared with the fetch-stage branch predictor.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] i_ifun,
  input  logic       i_zf,
  input  logic       i_sf,
  input  logic       i_of,
  output logic       o_cnd
);

  logic w_lt;

  assign w_lt = i_sf ^ i_of;

  // NOTE: o_cnd is given a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    o_cnd = 1'b0;
    case (i_ifun)
      C_ALWAYS: o_cnd = 1'b1;
      C_LE:     o_cnd = w_lt | i_zf;
      C_L:      o_cnd = w_lt;
      C_E:      o_cnd = i_zf;
      C_NE:     o_cnd = ~i_zf;
      C_GE:     o_cnd = ~w_lt;
      C_G:      o_cnd = ~w_lt & ~i_zf;
      default:  o_cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_exec_latch.sv
// Condition-code register (ZF/SF/OF) fed by the ALU adder, Cnd evaluation with cmov
// destination squash, and the E->M pipeline latch with stall/bubble control.
module cc_exec_latch
  import y86_pkg::*;
#(
  parameter int WIDTH = y86_pkg::WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  cc_exec_latch_if.slave         bus
);

  cc_t              r_cc;
  logic             w_cnd;
  logic [3:0]       w_dstE_eff;
  logic             w_cc_we;

  logic [3:0]       r_m_icode;
  logic             r_m_cnd;
  logic [3:0]       r_m_dstE;
  logic [WIDTH-1:0] r_m_valE;

  // Cnd must see the flags as registered, never the same-cycle adder result.
  cond_eval u_cond_eval (
    .i_ifun (bus.e_ifun),
    .i_zf   (r_cc.zf),
    .i_sf   (r_cc.sf),
    .i_of   (r_cc.of),
    .o_cnd  (w_cnd)
  );

  assign w_dstE_eff = (bus.e_icode == I_RRMOVQ && !w_cnd) ? RNONE : bus.e_dstE;
  assign w_cc_we    = bus.set_cc && !bus.cc_block;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cc <= CC_RESET;
    end else if (w_cc_we) begin
      r_cc.zf <= (bus.alu_sum == '0);
      r_cc.sf <= bus.alu_sum[WIDTH-1];
      r_cc.of <= bus.alu_ovf;
    end
  end

  // NOTE: reset is synchronous and wins over stall, so held contents are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_icode <= I_NOP;
      r_m_cnd   <= 1'b0;
      r_m_dstE  <= RNONE;
      r_m_valE  <= '0;
    end else if (bus.m_stall) begin
      r_m_icode <= r_m_icode;
      r_m_cnd   <= r_m_cnd;
      r_m_dstE  <= r_m_dstE;
      r_m_valE  <= r_m_valE;
    end else if (bus.m_bubble) begin
      r_m_icode <= I_NOP;
      r_m_cnd   <= 1'b0;
      r_m_dstE  <= RNONE;
      r_m_valE  <= '0;
    end else begin
      r_m_icode <= bus.e_icode;
      r_m_cnd   <= w_cnd;
      r_m_dstE  <= w_dstE_eff;
      r_m_valE  <= bus.alu_sum;
    end
  end

  assign bus.e_cnd   = w_cnd;
  assign bus.cc_zf   = r_cc.zf;
  assign bus.cc_sf   = r_cc.sf;
  assign bus.cc_of   = r_cc.of;
  assign bus.m_icode = r_m_icode;
  assign bus.m_cnd   = r_m_cnd;
  assign bus.m_dstE  = r_m_dstE;
  assign bus.m_valE  = r_m_valE;

endmodule

// File: tb/tb_cc_exec_latch.sv
// Directed bench for cc_exec_latch: reset, flag capture, cc_block, cmov squash,
// stall/bubble priority and reset during stall.
module tb_cc_exec_latch;
  import y86_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cc_exec_latch_if #(.WIDTH(64)) bus ();

  cc_exec_latch #(.WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.e_icode  = I_NOP;
    bus.e_ifun   = 4'h0;
    bus.e_dstE   = RNONE;
    bus.alu_sum  = '0;
    bus.alu_ovf  = 1'b0;
    bus.set_cc   = 1'b0;
    bus.cc_block = 1'b0;
    bus.m_stall  = 1'b0;
    bus.m_bubble = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.set_cc  = 1'b1;
    bus.alu_sum = 64'h5;
    bus.e_icode = I_OPQ;
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b100) begin
      errors++;
      $display("FAIL reset_cc got %b exp 100", {bus.cc_zf, bus.cc_sf, bus.cc_of});
    end
    checks++;
    if (bus.m_icode !== 4'h1 || bus.m_dstE !== 4'hF || bus.m_cnd !== 1'b0) begin
      errors++;
      $display("FAIL reset_latch got icode=%h dstE=%h cnd=%b exp 1 F 0",
               bus.m_icode, bus.m_dstE, bus.m_cnd);
    end
    checks++;
    if (bus.m_valE !== 64'h0) begin
      errors++;
      $display("FAIL reset_valE got %h exp 0", bus.m_valE);
    end
    rst = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_flags();
    bus.set_cc  = 1'b1;
    bus.e_icode = I_OPQ;
    bus.alu_sum = 64'h7FFF_FFFF_FFFF_FFFF;
    bus.alu_ovf = 1'b1;
    step();
    checks++;
    if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b001) begin
      errors++;
      $display("FAIL flags_capture got %b exp 001", {bus.cc_zf, bus.cc_sf, bus.cc_of});
    end
    idle_inputs();
    bus.e_ifun = 4'd2;
    #1;
    checks++;
    if (bus.e_cnd !== 1'b1) begin
      errors++;
      $display("FAIL cnd_l got %b exp 1", bus.e_cnd);
    end
    bus.e_ifun = 4'd5;
    #1;
    checks++;
    if (bus.e_cnd !== 1'b0) begin
      errors++;
      $display("FAIL cnd_ge got %b exp 0", bus.e_cnd);
    end
    bus.e_ifun = 4'd1;
    #1;
    checks++;
    if (bus.e_cnd !== 1'b1) begin
      errors++;
      $display("FAIL cnd_le got %b exp 1", bus.e_cnd);
    end
    bus.e_ifun = 4'd6;
    #1;
    checks++;
    if (bus.e_cnd !== 1'b0) begin
      errors++;
      $display("FAIL cnd_g got %b exp 0", bus.e_cnd);
    end
    bus.e_ifun = 4'd9;
    #1;
    checks++;
    if (bus.e_cnd !== 1'b0) begin
      errors++;
      $display("FAIL cnd_undef got %b exp 0", bus.e_cnd);
    end
  endtask

  task automatic test_cc_block();
    idle_inputs();
    bus.set_cc   = 1'b1;
    bus.alu_sum  = 64'h0;
    bus.cc_block = 1'b1;
    step();
    checks++;
    if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b001) begin
      errors++;
      $display("FAIL cc_block_hold got %b exp 001", {bus.cc_zf, bus.cc_sf, bus.cc_of});
    end
    bus.cc_block = 1'b0;
    step();
    checks++;
    if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b100) begin
      errors++;
      $display("FAIL cc_zero_update got %b exp 100", {bus.cc_zf, bus.cc_sf, bus.cc_of});
    end
    // Flags written one edge earlier must be visible to the next jXX: je now true.
    idle_inputs();
    bus.e_icode = I_JXX;
    bus.e_ifun  = 4'd3;
    #1;
    checks++;
    if (bus.e_cnd !== 1'b1) begin
      errors++;
      $display("FAIL cnd_je_after_set got %b exp 1", bus.e_cnd);
    end
  endtask

  task automatic test_squash();
    idle_inputs();
    bus.set_cc  = 1'b1;
    bus.alu_sum = 64'h5;
    step();
    idle_inputs();
    bus.e_icode = I_RRMOVQ;
    bus.e_ifun  = 4'd3;
    bus.e_dstE  = 4'h3;
    bus.alu_sum = 64'h77;
    step();
    checks++;
    if (bus.m_dstE !== 4'hF || bus.m_cnd !== 1'b0 || bus.m_icode !== 4'h2) begin
      errors++;
      $display("FAIL cmove_squash got dstE=%h cnd=%b icode=%h exp F 0 2",
               bus.m_dstE, bus.m_cnd, bus.m_icode);
    end
    bus.e_ifun = 4'd0;
    step();
    checks++;
    if (bus.m_dstE !== 4'h3 || bus.m_cnd !== 1'b1 || bus.m_valE !== 64'h77) begin
      errors++;
      $display("FAIL rrmovq_pass got dstE=%h cnd=%b valE=%h exp 3 1 77",
               bus.m_dstE, bus.m_cnd, bus.m_valE);
    end
    // Squash only applies to rrmovq/cmov, not to other icodes with a false Cnd.
    bus.e_icode = I_OPQ;
    bus.e_ifun  = 4'd3;
    step();
    checks++;
    if (bus.m_dstE !== 4'h3 || bus.m_icode !== 4'h6) begin
      errors++;
      $display("FAIL opq_no_squash got dstE=%h icode=%h exp 3 6", bus.m_dstE, bus.m_icode);
    end
  endtask

  task automatic test_stall_bubble();
    idle_inputs();
    bus.e_icode = I_OPQ;
    bus.e_dstE  = 4'h2;
    bus.alu_sum = 64'h1234;
    step();
    checks++;
    if (bus.m_valE !== 64'h1234) begin
      errors++;
      $display("FAIL load_valE got %h exp 1234", bus.m_valE);
    end
    bus.m_stall  = 1'b1;
    bus.m_bubble = 1'b1;
    bus.set_cc   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.alu_sum = 64'h8000_0000_0000_0000 | 64'(i);
      bus.e_icode = I_IRMOVQ;
      bus.e_dstE  = 4'(i);
      step();
      checks++;
      if (bus.m_valE !== 64'h1234 || bus.m_icode !== 4'h6 || bus.m_dstE !== 4'h2) begin
        errors++;
        $display("FAIL stall_hold[%0d] got valE=%h icode=%h dstE=%h exp 1234 6 2",
                 i, bus.m_valE, bus.m_icode, bus.m_dstE);
      end
    end
    // CC keeps updating while the latch is stalled.
    checks++;
    if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b010) begin
      errors++;
      $display("FAIL cc_during_stall got %b exp 010", {bus.cc_zf, bus.cc_sf, bus.cc_of});
    end
    bus.set_cc  = 1'b0;
    bus.m_stall = 1'b0;
    step();
    checks++;
    if (bus.m_icode !== 4'h1 || bus.m_valE !== 64'h0 || bus.m_dstE !== 4'hF
        || bus.m_cnd !== 1'b0) begin
      errors++;
      $display("FAIL bubble got icode=%h valE=%h dstE=%h cnd=%b exp 1 0 F 0",
               bus.m_icode, bus.m_valE, bus.m_dstE, bus.m_cnd);
    end
  endtask

  task automatic test_reset_mid_stall();
    idle_inputs();
    bus.e_icode = I_OPQ;
    bus.e_dstE  = 4'h4;
    bus.alu_sum = 64'hABCD;
    step();
    bus.m_stall = 1'b1;
    step();
    checks++;
    if (bus.m_valE !== 64'hABCD) begin
      errors++;
      $display("FAIL pre_reset_hold got %h exp abcd", bus.m_valE);
    end
    rst         = 1'b1;
    bus.set_cc  = 1'b1;
    bus.alu_sum = 64'h5;
    step();
    checks++;
    if (bus.m_icode !== 4'h1 || bus.m_valE !== 64'h0 || bus.m_dstE !== 4'hF) begin
      errors++;
      $display("FAIL reset_in_stall got icode=%h valE=%h dstE=%h exp 1 0 F",
               bus.m_icode, bus.m_valE, bus.m_dstE);
    end
    checks++;
    if ({bus.cc_zf, bus.cc_sf, bus.cc_of} !== 3'b100) begin
      errors++;
      $display("FAIL reset_over_set_cc got %b exp 100", {bus.cc_zf, bus.cc_sf, bus.cc_of});
    end
    rst = 1'b0;
    idle_inputs();
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_flags();
    test_cc_block();
    test_squash();
    test_stall_bubble();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
